// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controlWord field layout, Psel encodings and the
// fetch/sequencing phase enum used by pc_sequencer and pc_next.
package cpu_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CW_W    = 29;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned PSEL_W  = 2;

  // controlWord bit offsets
  localparam int unsigned PSEL_HI   = 28;
  localparam int unsigned PSEL_LO   = 27;
  localparam int unsigned DA_HI     = 26;
  localparam int unsigned DA_LO     = 22;
  localparam int unsigned SA_HI     = 21;
  localparam int unsigned SA_LO     = 17;
  localparam int unsigned SB_HI     = 16;
  localparam int unsigned SB_LO     = 12;
  localparam int unsigned FSEL_HI   = 11;
  localparam int unsigned FSEL_LO   = 7;
  localparam int unsigned REGW_BIT  = 6;
  localparam int unsigned RAMW_BIT  = 5;
  localparam int unsigned DSEL_HI   = 4;
  localparam int unsigned DSEL_LO   = 3;
  localparam int unsigned BSEL_BIT  = 2;
  localparam int unsigned PCSEL_BIT = 1;
  localparam int unsigned SL_BIT    = 0;

  localparam logic [PSEL_W-1:0] PSEL_HOLD = 2'b00;
  localparam logic [PSEL_W-1:0] PSEL_INC  = 2'b01;
  localparam logic [PSEL_W-1:0] PSEL_LOAD = 2'b10;
  localparam logic [PSEL_W-1:0] PSEL_REL  = 2'b11;

  typedef enum logic [1:0] {
    RESET_IDLE = 2'd0,
    FETCH      = 2'd1,
    EXEC       = 2'd2,
    FAULT      = 2'd3
  } phase_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC computation and misaligned-load detection.
// PC_ALIGN_CHECK_EN: keep raw Psel=10 target so misalignment can be flagged.
module pc_next
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]   pc_i,
  input  logic [PSEL_W-1:0] psel_i,
  input  logic              pcsel_i,
  input  logic [PC_W-1:0]   k_i,
  input  logic [PC_W-1:0]   rega_i,
  output logic [PC_W-1:0]   pc_nxt_o,
  output logic              misalign_o
);

  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] load_tgt;
  logic [PC_W-1:0] pc_inc;

  assign tgt    = pcsel_i ? k_i : rega_i;
  assign pc_inc = pc_i + PC_W'(4);

`ifdef PC_ALIGN_CHECK_EN
  assign load_tgt = tgt;
`else
  assign load_tgt = {tgt[PC_W-1:2], 2'b00};
`endif

  assign misalign_o = (psel_i == PSEL_LOAD) && (load_tgt[1:0] != 2'b00);

  // Relative branch drops tgt[63:62] by shifting within 64 bits
  always_comb begin
    pc_nxt_o = pc_i;
    case (psel_i)
      PSEL_HOLD: pc_nxt_o = pc_i;
      PSEL_INC:  pc_nxt_o = pc_inc;
      PSEL_LOAD: pc_nxt_o = load_tgt;
      PSEL_REL:  pc_nxt_o = pc_inc + {tgt[PC_W-3:0], 2'b00};
      default:   pc_nxt_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/sequencing unit: owns PC, instruction register and decoder micro-state.
// PC_ALIGN_CHECK_EN enables the misaligned Psel=10 target fault (see pc_next).
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'd0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [CW_W-1:0]    controlWord,
  input  logic [PC_W-1:0]    K,
  input  logic [STATE_W-1:0] nextState,
  input  logic [PC_W-1:0]    regA,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [STATE_W-1:0] state,
  output logic [PC_W-1:0]    PC,
  output logic               exec,
  output logic               regW_en,
  output logic               ramW_en,
  output logic               fault
);

  phase_e              phase_q, phase_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic                req_q, req_d;
  logic                fault_q, fault_d;
  logic [PC_W-1:0]     pc_nxt;
  logic                misalign;
  logic                unused_cw;

  // Fields consumed by the datapath, not by the sequencer
  assign unused_cw = ^{controlWord[DA_HI:FSEL_LO], controlWord[DSEL_HI:BSEL_BIT],
                       controlWord[SL_BIT]};

  pc_next u_pc_next (
    .pc_i       (pc_q),
    .psel_i     (controlWord[PSEL_HI:PSEL_LO]),
    .pcsel_i    (controlWord[PCSEL_BIT]),
    .k_i        (K),
    .rega_i     (regA),
    .pc_nxt_o   (pc_nxt),
    .misalign_o (misalign)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= RESET_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      state_q <= '0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      state_q <= state_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end

  // Phase sequencing; req/fault are registered from the next phase
  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    state_d = state_q;
    case (phase_q)
      RESET_IDLE: phase_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = '0;
          phase_d = EXEC;
        end
      end
      EXEC: begin
        if (misalign) begin
          phase_d = FAULT;
        end else begin
          pc_d    = pc_nxt;
          state_d = nextState;
          phase_d = (nextState == '0) ? FETCH : EXEC;
        end
      end
      FAULT:   phase_d = FAULT;
      default: phase_d = RESET_IDLE;
    endcase
    req_d   = (phase_d == FETCH);
    fault_d = (phase_d == FAULT);
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign instruction = instr_q;
  assign state       = state_q;
  assign fault       = fault_q;
  assign exec        = (phase_q == EXEC);
  assign regW_en     = exec & controlWord[REGW_BIT];
  assign ramW_en     = exec & controlWord[RAMW_BIT];

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses are queued as
// each instruction executes and popped when the DUT issues the next fetch.
module tb_pc_sequencer;

  localparam logic [63:0] TB_RESET_PC = 64'd0;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [28:0] controlWord;
  logic [63:0] K;
  logic [1:0]  nextState;
  logic [63:0] regA;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic [63:0] PC;
  logic        exec;
  logic        regW_en;
  logic        ramW_en;
  logic        fault;

  always #5 clock = ~clock;

  pc_sequencer #(.RESET_PC(TB_RESET_PC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .controlWord (controlWord),
    .K           (K),
    .nextState   (nextState),
    .regA        (regA),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .state       (state),
    .PC          (PC),
    .exec        (exec),
    .regW_en     (regW_en),
    .ramW_en     (ramW_en),
    .fault       (fault)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_addr_q[$];
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [1:0]  m_state;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [28:0] make_cw(input logic [1:0] psel, input logic pcsel,
                                          input logic regw, input logic ramw);
    logic [28:0] cw;
    cw      = '0;
    cw[28:27] = psel;
    cw[6]   = regw;
    cw[5]   = ramw;
    cw[1]   = pcsel;
    return cw;
  endfunction

  function automatic logic [63:0] model_pc(input logic [63:0] pc, input logic [1:0] psel,
                                           input logic pcsel, input logic [63:0] k,
                                           input logic [63:0] ra);
    logic [63:0] tgt;
    tgt = pcsel ? k : ra;
    case (psel)
      2'd1:    return pc + 64'd4;
      2'd2:    return tgt & ~64'd3;
      2'd3:    return pc + 64'd4 + (tgt << 2);
      default: return pc;
    endcase
  endfunction

  // Asynchronous reset from any point in a cycle; returns one cycle into FETCH
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_pc", PC, TB_RESET_PC);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_misc", 64'({state, exec, regW_en, ramW_en, fault}), 64'd0);
    imem_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    m_pc    = TB_RESET_PC;
    m_instr = '0;
    m_state = '0;
    exp_addr_q.delete();
    exp_addr_q.push_back(TB_RESET_PC);
    chk("idle_req", 64'(imem_req), 64'd0);
    tick();
    chk("first_req", 64'(imem_req), 64'd1);
  endtask

  task automatic do_fetch(input int waits, input logic [31:0] word);
    int n = 0;
    controlWord = '1;
    nextState   = 2'd3;
    imem_ack    = 1'b0;
    #1;
    while (imem_req !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("req_seen", 64'(imem_req), 64'd1);
    chk("fetch_gate", 64'({exec, regW_en, ramW_en}), 64'd0);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait_req", 64'(imem_req), 64'd1);
      chk("wait_instr", 64'(instruction), 64'(m_instr));
    end
    if (exp_addr_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    m_instr  = word;
    m_state  = '0;
    chk("instr", 64'(instruction), 64'(word));
    chk("req_off", 64'(imem_req), 64'd0);
  endtask

  task automatic do_exec(input logic [1:0] psel, input logic pcsel, input logic [63:0] k,
                         input logic [63:0] ra, input logic regw, input logic ramw,
                         input logic [1:0] ns);
    controlWord = make_cw(psel, pcsel, regw, ramw);
    K           = k;
    regA        = ra;
    nextState   = ns;
    #1;
    chk("exec", 64'(exec), 64'd1);
    chk("state", 64'(state), 64'(m_state));
    chk("regW_en", 64'(regW_en), 64'(regw));
    chk("ramW_en", 64'(ramW_en), 64'(ramw));
    chk("pc_exec", PC, m_pc);
    m_pc = model_pc(m_pc, psel, pcsel, k, ra);
    tick();
    m_state = ns;
    chk("fault_low", 64'(fault), 64'd0);
    if (ns == 2'd0) exp_addr_q.push_back(m_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b1;
    controlWord = '0;
    K           = '0;
    nextState   = '0;
    regA        = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    #2;
    do_reset();

    // Relative branch K=3 from 0 -> 0x10
    do_fetch(0, 32'h1400_0003);
    do_exec(2'd3, 1'b1, 64'd3, 64'd0, 1'b0, 1'b0, 2'd0);

    // Three wait states, then PC+4
    do_fetch(3, 32'h9100_0421);
    do_exec(2'd1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 2'd0);

    // Two-cycle instruction: state 0 then 2, regW_en in both
    do_fetch(0, 32'hB400_0040);
    do_exec(2'd1, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 2'd2);
    do_exec(2'd0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 2'd0);

    // Misaligned register target 0x1002
    do_fetch(1, 32'hD61F_0000);
`ifdef PC_ALIGN_CHECK_EN
    controlWord = make_cw(2'd2, 1'b0, 1'b0, 1'b0);
    regA        = 64'h1002;
    nextState   = 2'd0;
    tick();
    chk("fault_set", 64'(fault), 64'd1);
    chk("fault_pc", PC, m_pc);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_req", 64'({imem_req, exec}), 64'd0);
    end
    do_reset();
`else
    do_exec(2'd2, 1'b0, 64'd0, 64'h1002, 1'b0, 1'b0, 2'd0);
`endif

    // Absolute K=8 with RAM write, then PC+4+(-1<<2) stays at 8
    do_fetch(0, 32'h1400_0002);
    do_exec(2'd2, 1'b1, 64'd8, 64'd0, 1'b0, 1'b1, 2'd0);
    do_fetch(2, 32'h17FF_FFFF);
    do_exec(2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 2'd0);

    // Reset mid-fetch with ack pending
    controlWord = '1;
    #1;
    while (imem_req !== 1'b1) tick();
    chk("pre_rst_pc", PC, 64'd8);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    do_reset();

    // Stray ack during EXEC must not reload the instruction register
    do_fetch(0, 32'h9100_0800);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    do_exec(2'd1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 2'd0);
    imem_ack = 1'b0;
    chk("stray_ack", 64'(instruction), 64'h9100_0800);

    // Wrap past the top of the address space
    do_fetch(0, 32'h1400_0010);
    do_exec(2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0, 1'b0, 2'd0);
    do_fetch(1, 32'h9100_0000);
    do_exec(2'd1, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 2'd0);
    do_fetch(0, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/sequencing unit that consumes the 29-bit control word, K and nextState produced by the per-opcode decoders (B, CBZ, ADDI, …). It owns the program counter, the instruction register and the 2-bit decoder state register, and runs a fetch handshake with instruction memory. It also gates the register-file and RAM write enables so they fire only in the execute cycle.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- controlWord  input  29  {Psel[28:27], DA[26:22], SA[21:17], SB[16:12], Fsel[11:7], regW[6], ramW[5], Dsel[4:3], Bsel[2], PCsel[1], SL[0]}.
- K  input  64  decoder constant.
- nextState  input  2  decoder's next micro-state.
- regA  input  64  register-file A bus (BR target source).
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  64  fetch address (= PC).
- imem_ack  input  1  instruction memory returns data this cycle.
- imem_rdata  input  32  fetched instruction word.
- instruction  output  32  instruction register, fed to the decoders.
- state  output  2  current micro-state, fed to the decoders.
- PC  output  64  program counter.
- exec  output  1  high during an execute cycle.
- regW_en  output  1  controlWord.regW AND exec.
- ramW_en  output  1  controlWord.ramW AND exec.
- fault  output  1  misaligned-target fault (see Configuration).

## Operation
- Phase FSM: RESET_IDLE → FETCH → EXEC → (FETCH | EXEC) ; FAULT sink.
- RESET_IDLE: entered from reset, lasts exactly one cycle, then goes to FETCH.
- FETCH: imem_req=1 and imem_addr=PC. On imem_ack: instruction ← imem_rdata, state ← 0, next phase EXEC. Without ack: hold, keep imem_req high.
- EXEC: exec=1. The decoders see instruction and state. At the clock edge:
  - state ← nextState.
  - PC updated per Psel.
  - If nextState==0: go to FETCH. Otherwise stay in EXEC (multi-cycle instruction); the PC update still applies every EXEC cycle.
- Psel: 00 PC held; 01 PC+4; 10 PC ← tgt; 11 PC ← PC+4+(tgt<<2). tgt = PCsel ? K : regA.
- Arithmetic is 64-bit modulo 2^64. Wrap past 64'hFFFF_FFFF_FFFF_FFFC is silent. The shift discards tgt[63:62].
- imem_ack outside FETCH is ignored.
- regW_en/ramW_en are 0 outside EXEC, regardless of controlWord.

## Timing
- Reset values: PC=RESET_PC, instruction=0, state=0, phase=RESET_IDLE, imem_req=0, exec=0, regW_en=0, ramW_en=0, fault=0.
- reset_n low mid-fetch or mid-exec aborts immediately and asynchronously. A pending ack is discarded.
- First imem_req is asserted in the 2nd cycle after reset_n deasserts.
- Single-cycle instruction with zero-wait memory: 2 cycles per instruction (FETCH with ack, then EXEC).
- Each extra memory wait cycle adds 1 cycle. Each nonzero nextState adds 1 EXEC cycle.
- New PC is visible on imem_addr in the FETCH cycle directly after the final EXEC.
- Outputs are registered except regW_en/ramW_en/exec. Those are decoded from the phase register and controlWord and have no combinational path from imem_*.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - In EXEC with Psel=10 and tgt[1:0]≠0, PC is not updated; the FSM enters FAULT.
  - In FAULT: fault=1, imem_req=0, exec=0. The state is held until reset.
  - Psel=11 cannot misalign and is not checked.
- PC_ALIGN_CHECK_EN undefined: the Psel=10 target has bits [1:0] forced to 0, and fault is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - controlWord field bit-offset constants (PSEL_HI/LO … SL_BIT).
  - Psel encodings (PSEL_HOLD, PSEL_INC, PSEL_LOAD, PSEL_REL).
  - The phase enum (RESET_IDLE, FETCH, EXEC, FAULT).
- One combinational sub-module, pc_next, computes the next PC and the misalignment flag from PC, Psel, PCsel, K and regA.
- The FSM and registers live in pc_sequencer.

## Test plan
- Reset release, memory acks immediately with 32'h14000003 each fetch; drive Psel=11, PCsel=1, K=3 → imem_addr 0, then PC=0+4+12=0x10 at the next fetch.
- Psel=01 with imem_ack delayed 3 cycles → imem_req held 4 cycles, instruction latched only on the ack cycle, PC advances by 4 once.
- Decoder drives nextState=2 then 0 → two EXEC cycles with state=0 then 2, regW_en high in both when regW=1, then FETCH.
- Psel=10, PCsel=0, regA=0x1002:
  - With PC_ALIGN_CHECK_EN → fault=1, imem_req stays 0 and PC unchanged.
  - Without the macro → PC=0x1000.
- reset_n pulsed low during FETCH with imem_ack high → PC=RESET_PC, imem_req=0 and instruction=0 immediately; the ack is not latched.
- Psel=11, K=64'hFFFF_FFFF_FFFF_FFFF (−1), PC=0x8 → PC=0x8 (8+4−4), exercising sign extension.
